// File: rtl/falling_char_lanes_pkg.sv
// Shared defaults, scan FSM state encoding and saturating counter helper
// for the falling-character lane engine.
package char_lane_pkg;

    localparam int CHAR_W_DEF   = 8;
    localparam int CHAR_H_DEF   = 16;
    localparam int SCREEN_H_DEF = 480;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        CHECK
    } scan_state_e;

    function automatic logic [15:0] sat_inc(input logic [15:0] val, input logic [15:0] amt);
        logic [16:0] sum;
        sum = {1'b0, val} + {1'b0, amt};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/falling_char_lanes_if.sv
// Spawn and key handshakes between the game controller and the lane engine.
interface falling_char_lanes_if #(
    parameter int LANES = 80,
    parameter int SPD_W = 4
);
    localparam int LW = $clog2(LANES);

    logic             spawn_valid;
    logic             spawn_ready;
    logic [LW-1:0]    spawn_lane;
    logic [7:0]       spawn_char;
    logic [SPD_W-1:0] spawn_speed;

    logic             key_valid;
    logic             key_ready;
    logic [7:0]       key_char;
    logic             key_done;
    logic             key_hit;
    logic [LW-1:0]    key_lane;

    modport master (
        output spawn_valid, spawn_lane, spawn_char, spawn_speed, key_valid, key_char,
        input  spawn_ready, key_ready, key_done, key_hit, key_lane
    );

    modport slave (
        input  spawn_valid, spawn_lane, spawn_char, spawn_speed, key_valid, key_char,
        output spawn_ready, key_ready, key_done, key_hit, key_lane
    );

endinterface

// File: rtl/falling_char_lanes_key_scan_fsm.sv
// Walks all lanes one per cycle looking for the lowest on-screen match of a
// typed key, then re-validates the winner before clearing it.
module key_scan_fsm
    import char_lane_pkg::*;
#(
    parameter int LANES = 80
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       key_valid,
    output logic                       key_ready,
    input  logic [7:0]                 key_char,
    output logic                       key_done,
    output logic                       key_hit,
    output logic [$clog2(LANES)-1:0]   key_lane,
    output logic [$clog2(LANES)-1:0]   rd_idx,
    input  logic                       rd_act,
    input  logic                       rd_kill,
    input  logic [7:0]                 rd_ch,
    input  logic [8:0]                 rd_y,
    output logic                       clr_en,
    output logic [$clog2(LANES)-1:0]   clr_lane
);
    localparam int LW = $clog2(LANES);

    scan_state_e   state_q, state_d;
    logic [LW-1:0] idx_q, idx_d, best_q, best_d, lane_q, lane_d;
    logic [7:0]    key_q, key_d;
    logic [8:0]    best_y_q, best_y_d;
    logic          found_q, found_d, done_q, done_d, hit_q, hit_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            best_q   <= '0;
            lane_q   <= '0;
            key_q    <= '0;
            best_y_q <= '0;
            found_q  <= 1'b0;
            done_q   <= 1'b0;
            hit_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            best_q   <= best_d;
            lane_q   <= lane_d;
            key_q    <= key_d;
            best_y_q <= best_y_d;
            found_q  <= found_d;
            done_q   <= done_d;
            hit_q    <= hit_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        best_d    = best_q;
        lane_d    = lane_q;
        key_d     = key_q;
        best_y_d  = best_y_q;
        found_d   = found_q;
        done_d    = 1'b0;
        hit_d     = hit_q;
        key_ready = 1'b0;
        clr_en    = 1'b0;
        rd_idx    = idx_q;
        unique case (state_q)
            IDLE: begin
                key_ready = 1'b1;
                if (key_valid) begin
                    key_d    = key_char;
                    idx_d    = '0;
                    best_d   = '0;
                    best_y_d = '0;
                    found_d  = 1'b0;
                    state_d  = SCAN;
                end
            end
            SCAN: begin
                // strict greater-than keeps the lower index on equal heights
                if (rd_act && rd_ch == key_q && (!found_q || rd_y > best_y_q)) begin
                    found_d  = 1'b1;
                    best_d   = idx_q;
                    best_y_d = rd_y;
                end
                if (idx_q == LW'(LANES - 1)) state_d = CHECK;
                else                         idx_d   = idx_q + 1'b1;
            end
            CHECK: begin
                // the winner may have been retired by a tick since it was picked
                rd_idx  = best_q;
                clr_en  = found_q && rd_act && !rd_kill && rd_ch == key_q;
                done_d  = 1'b1;
                hit_d   = clr_en;
                lane_d  = clr_en ? best_q : '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign key_done = done_q;
    assign key_hit  = hit_q;
    assign key_lane = lane_q;
    assign clr_lane = best_q;

endmodule

// File: rtl/falling_char_lanes.sv
// Lane state engine for the falling-character game: spawn, move/retire,
// key matching via key_scan_fsm, and registered glyph-ROM lookup for VGA.
module falling_char_lanes
    import char_lane_pkg::*;
#(
    parameter int LANES    = 80,
    parameter int CHAR_W   = CHAR_W_DEF,
    parameter int CHAR_H   = CHAR_H_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF,
    parameter int SPD_W    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        tick,
    falling_char_lanes_if.slave         bus,
    output logic                        miss_valid,
    output logic [LANES-1:0]            miss_mask,
    input  logic [9:0]                  h_addr,
    input  logic [9:0]                  v_addr,
    output logic                        glyph_en,
    output logic [11:0]                 rom_addr,
    output logic [$clog2(CHAR_W)-1:0]   glyph_col,
    output logic [LANES-1:0]            active_mask,
    output logic [15:0]                 hit_count,
    output logic [15:0]                 miss_count
);
    localparam int         LW     = $clog2(LANES);
    localparam int         CWL    = $clog2(CHAR_W);
    localparam logic [9:0] Y_LAST = 10'(SCREEN_H - CHAR_H);

    logic [LANES-1:0]            act;
    logic [LANES-1:0][7:0]       ch;
    logic [LANES-1:0][8:0]       y;
    logic [LANES-1:0][8:0]       y_nxt;
    logic [LANES-1:0][SPD_W-1:0] spd;
    logic [LANES-1:0]            retire;

    logic          sp_in_range, spawn_fire;
    logic [LW-1:0] sp_idx;
    logic [SPD_W-1:0] spawn_spd;
    logic          clr_en;
    logic [LW-1:0] rd_idx, clr_lane;

    assign sp_in_range     = {1'b0, bus.spawn_lane} < (LW + 1)'(LANES);
    assign sp_idx          = sp_in_range ? bus.spawn_lane : '0;
    assign bus.spawn_ready = sp_in_range && !act[sp_idx];
    assign spawn_fire      = bus.spawn_valid && bus.spawn_ready;
    assign spawn_spd       = (bus.spawn_speed == '0) ? SPD_W'(1) : bus.spawn_speed;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [9:0] nxt;
        assign nxt       = {1'b0, y[i]} + 10'(spd[i]);
        assign retire[i] = tick && act[i] && (nxt > Y_LAST);
        assign y_nxt[i]  = nxt[8:0];
    end

    // spawn only targets inactive lanes, so it never collides with a retire or clear
    always_ff @(posedge clk) begin
        if (!rst) begin
            act <= '0;
            ch  <= '0;
            y   <= '0;
            spd <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (spawn_fire && sp_idx == LW'(i)) begin
                    act[i] <= 1'b1;
                    ch[i]  <= bus.spawn_char;
                    y[i]   <= '0;
                    spd[i] <= spawn_spd;
                end else if (retire[i] || (clr_en && clr_lane == LW'(i))) begin
                    act[i] <= 1'b0;
                end else if (tick && act[i]) begin
                    y[i] <= y_nxt[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            miss_valid  <= 1'b0;
            miss_mask   <= '0;
            miss_count  <= '0;
            hit_count   <= '0;
            active_mask <= '0;
        end else begin
            miss_valid  <= |retire;
            miss_mask   <= retire;
            miss_count  <= sat_inc(miss_count, 16'($countones(retire)));
            if (clr_en) hit_count <= sat_inc(hit_count, 16'd1);
            active_mask <= act;
        end
    end

    key_scan_fsm #(.LANES(LANES)) u_scan (
        .clk       (clk),
        .rst       (rst),
        .key_valid (bus.key_valid),
        .key_ready (bus.key_ready),
        .key_char  (bus.key_char),
        .key_done  (bus.key_done),
        .key_hit   (bus.key_hit),
        .key_lane  (bus.key_lane),
        .rd_idx    (rd_idx),
        .rd_act    (act[rd_idx]),
        .rd_kill   (retire[rd_idx]),
        .rd_ch     (ch[rd_idx]),
        .rd_y      (y[rd_idx]),
        .clr_en    (clr_en),
        .clr_lane  (clr_lane)
    );

    logic          pix_in, pix_en;
    logic [LW-1:0] pix_lane;
    logic [9:0]    pix_y, pix_row;

    assign pix_in   = h_addr < 10'(LANES * CHAR_W);
    assign pix_lane = pix_in ? LW'(h_addr >> CWL) : '0;
    assign pix_y    = {1'b0, y[pix_lane]};
    assign pix_row  = v_addr - pix_y;
    assign pix_en   = pix_in && act[pix_lane] && (v_addr >= pix_y) && (pix_row < 10'(CHAR_H));

    always_ff @(posedge clk) begin
        if (!rst) begin
            glyph_en  <= 1'b0;
            rom_addr  <= '0;
            glyph_col <= '0;
        end else begin
            glyph_en  <= pix_en;
            rom_addr  <= pix_en ? {ch[pix_lane], pix_row[3:0]} : 12'h000;
            glyph_col <= h_addr[CWL-1:0];
        end
    end

endmodule

// File: tb/tb_falling_char_lanes.sv
// Directed checks of spawn, move/retire, key scan and pixel lookup.
module tb_falling_char_lanes;
    localparam int LANES = 80;
    localparam int KLAT  = LANES + 1;  // edges after the accepting edge until key_done

    logic clk = 1'b0, rst = 1'b0, tick = 1'b0;
    logic [9:0] h_addr = '0, v_addr = '0;
    logic miss_valid, glyph_en;
    logic [LANES-1:0] miss_mask, active_mask;
    logic [11:0] rom_addr;
    logic [2:0] glyph_col;
    logic [15:0] hit_count, miss_count;
    logic [LANES-1:0] one = 1;
    logic [LANES-1:0] mm;
    int n_chk = 0, n_err = 0;
    int lat, seen;

    falling_char_lanes_if #(.LANES(LANES), .SPD_W(4)) bus ();

    falling_char_lanes #(.LANES(LANES)) dut (
        .clk(clk), .rst(rst), .tick(tick), .bus(bus),
        .miss_valid(miss_valid), .miss_mask(miss_mask),
        .h_addr(h_addr), .v_addr(v_addr),
        .glyph_en(glyph_en), .rom_addr(rom_addr), .glyph_col(glyph_col),
        .active_mask(active_mask), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LANES-1:0] got, input logic [LANES-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; tick = 1'b0;
        bus.spawn_valid = 1'b0; bus.spawn_lane = '0; bus.spawn_char = '0; bus.spawn_speed = '0;
        bus.key_valid = 1'b0; bus.key_char = '0;
        step(); step();
        rst = 1'b1;
    endtask

    task automatic spawn(input int lane, input logic [7:0] c, input logic [3:0] s);
        bus.spawn_valid = 1'b1; bus.spawn_lane = 7'(lane); bus.spawn_char = c; bus.spawn_speed = s;
        step();
        bus.spawn_valid = 1'b0;
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        repeat (n) step();
        tick = 1'b0;
    endtask

    // tick_at: step number after acceptance on which to pulse tick (0 = never)
    task automatic run_key(input logic [7:0] c, input int tick_at, output int l, output logic [LANES-1:0] m);
        bus.key_valid = 1'b1; bus.key_char = c;
        step();
        bus.key_valid = 1'b0;
        chk("key_ready_busy", bus.key_ready, 0);
        l = 0; m = '0;
        while (!bus.key_done && l < 200) begin
            l++;
            tick = (l == tick_at);
            step();
            if (tick) m = miss_mask;
            tick = 1'b0;
        end
    endtask

    initial begin
        // reset state, sampled while rst is held low
        do_reset();
        rst = 1'b0; step();
        chk("rst_key_ready", bus.key_ready, 1);
        chk("rst_key_done", bus.key_done, 0);
        chk("rst_active", active_mask, 0);
        chk("rst_glyph_en", glyph_en, 0);
        chk("rst_counts", {hit_count, miss_count}, 0);
        rst = 1'b1;

        // spawn, move 5 ticks at speed 2, pixel lookup around y=10
        bus.spawn_valid = 1'b1; bus.spawn_lane = 7'd3; bus.spawn_char = 8'h41; bus.spawn_speed = 4'd2;
        #1 chk("spawn_ready_idle", bus.spawn_ready, 1);
        step();
        bus.spawn_valid = 1'b0;
        chk("active_mask_lag", active_mask, 0);
        step();
        chk("active_mask_spawn", active_mask, one << 3);
        chk("spawn_ready_busy", bus.spawn_ready, 0);
        ticks(5);
        h_addr = 10'd26; v_addr = 10'd14; step();
        chk("pix_en", glyph_en, 1);
        chk("pix_rom", rom_addr, 12'h414);
        chk("pix_col", glyph_col, 2);
        v_addr = 10'd25; step();
        chk("pix_last_row", rom_addr, 12'h41F);
        v_addr = 10'd26; step();
        chk("pix_below_en", glyph_en, 0);
        chk("pix_below_rom", rom_addr, 0);
        v_addr = 10'd9; step();
        chk("pix_above_en", glyph_en, 0);
        h_addr = 10'd700; v_addr = 10'd14; step();
        chk("pix_offscreen", glyph_en, 0);

        // out-of-range lane, zero speed clamp, retirement at the bottom
        do_reset();
        bus.spawn_valid = 1'b1; bus.spawn_lane = 7'd80; bus.spawn_char = 8'h55; bus.spawn_speed = 4'd1;
        #1 chk("spawn_ready_oor", bus.spawn_ready, 0);
        step(); bus.spawn_valid = 1'b0; step();
        chk("oor_not_spawned", active_mask, 0);
        spawn(1, 8'h59, 4'd0);
        ticks(3);
        h_addr = 10'd8; v_addr = 10'd3; step();
        chk("spd0_pix_rom", rom_addr, 12'h590);
        v_addr = 10'd2; step();
        chk("spd0_pix_above", glyph_en, 0);
        spawn(0, 8'h58, 4'd15);
        tick = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            step();
            if (k == 30) chk("no_miss_at_450", miss_valid, 0);
        end
        tick = 1'b0;
        chk("miss_valid", miss_valid, 1);
        chk("miss_mask", miss_mask, one);
        chk("miss_count", miss_count, 1);
        bus.spawn_lane = 7'd0;
        step();
        chk("miss_pulse", miss_valid, 0);
        chk("spawn_ready_after_miss", bus.spawn_ready, 1);
        chk("active_after_miss", active_mask, one << 1);

        // two 'B' lanes: the lower one on screen (lane 9, y=100) wins
        do_reset();
        spawn(9, 8'h42, 4'd10);
        ticks(6);
        spawn(5, 8'h42, 4'd10);
        ticks(4);
        chk("key_ready_idle", bus.key_ready, 1);
        run_key(8'h42, 0, lat, mm);
        chk("key_latency", lat, KLAT);
        chk("key_hit", bus.key_hit, 1);
        chk("key_lane", bus.key_lane, 9);
        chk("hit_count", hit_count, 1);
        step();
        chk("key_done_pulse", bus.key_done, 0);
        chk("key_hit_hold", bus.key_hit, 1);
        chk("active_after_hit", active_mask, one << 5);

        // 'Z' matches nothing; a 'B' offered mid-scan must be ignored
        bus.key_valid = 1'b1; bus.key_char = 8'h5A;
        step();
        bus.key_valid = 1'b0;
        step(); step(); step();
        bus.key_valid = 1'b1; bus.key_char = 8'h42;
        step();
        chk("key_ready_scan", bus.key_ready, 0);
        step();
        bus.key_valid = 1'b0;
        lat = 5;
        while (!bus.key_done && lat < 200) begin step(); lat++; end
        chk("miss_key_latency", lat, KLAT);
        chk("miss_key_hit", bus.key_hit, 0);
        chk("miss_key_lane", bus.key_lane, 0);
        step(); step();
        chk("ignored_key_done", bus.key_done, 0);
        chk("ignored_key_hits", hit_count, 1);
        chk("ignored_key_lane5", active_mask, one << 5);

        // candidate retired by a tick during SCAN
        do_reset();
        spawn(7, 8'h43, 4'd14);
        ticks(33);
        chk("lane7_at_462", miss_count, 0);
        run_key(8'h43, 10, lat, mm);
        chk("scan_tick_mask", mm, one << 7);
        chk("scan_tick_lat", lat, KLAT);
        chk("scan_tick_hit", bus.key_hit, 0);
        chk("scan_tick_hits", hit_count, 0);
        chk("scan_tick_misses", miss_count, 1);

        // tick retires the lane on the same edge CHECK would clear it
        spawn(7, 8'h43, 4'd14);
        ticks(33);
        run_key(8'h43, KLAT, lat, mm);
        chk("check_tick_mask", mm, one << 7);
        chk("check_tick_done", bus.key_done, 1);
        chk("check_tick_hit", bus.key_hit, 0);
        chk("check_tick_hits", hit_count, 0);
        chk("check_tick_misses", miss_count, 2);

        // spawn and tick together on an idle lane leave y at 0
        do_reset();
        bus.spawn_valid = 1'b1; bus.spawn_lane = 7'd2; bus.spawn_char = 8'h53; bus.spawn_speed = 4'd5;
        tick = 1'b1;
        step();
        bus.spawn_valid = 1'b0; tick = 1'b0;
        h_addr = 10'd16; v_addr = 10'd0; step();
        chk("spawn_tick_en", glyph_en, 1);
        chk("spawn_tick_rom", rom_addr, 12'h530);

        // reset in the middle of a scan aborts it silently
        spawn(4, 8'h51, 4'd1);
        bus.key_valid = 1'b1; bus.key_char = 8'h51;
        step();
        bus.key_valid = 1'b0;
        repeat (20) step();
        rst = 1'b0; step();
        chk("midrst_key_done", bus.key_done, 0);
        chk("midrst_key_ready", bus.key_ready, 1);
        chk("midrst_active", active_mask, 0);
        chk("midrst_glyph", {glyph_en, rom_addr}, 0);
        chk("midrst_key_out", {bus.key_hit, bus.key_lane}, 0);
        rst = 1'b1;
        seen = 0;
        repeat (100) begin
            step();
            if (bus.key_done) seen = 1;
        end
        chk("midrst_no_done", seen, 0);
        chk("midrst_hits", hit_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
